data_mem_responder: RTL and testbench

//  Responder side of the core's load/store port: accepts one load/store request per

---
 rtl/data_mem_responder_if.sv | 24 ++
 rtl/data_mem_responder.sv | 183 ++++++++++++++++++
 tb/tb_data_mem_responder.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Load/store port bundle between the core (master) and the data-memory responder (slave).
// Request fields are sampled on the req_valid & req_ready handshake. Response fields are
// meaningful only while rsp_valid is high.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_func3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_func3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: answers one RV32I load/store at a time from word-organised RAM.
// A request is accepted in IDLE. The FSM then spends WAIT_CYC cycles in WAIT and one
// cycle in RESP. The response appears as a registered one-cycle pulse.
// Optional feature macro DMEM_CYCLE_CNT_EN adds a read-only free-running cycle counter.
// The counter is mapped at byte address 0xFFFF_FF00 and answers only to LW.
module data_mem_responder #(
    parameter int ADDR_W   = 8,
    parameter int WAIT_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] WAIT_LAST = 4'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);

    state_t              state_reg, state_next;
    logic [3:0]          wait_cnt_reg;

    logic                we_reg;
    logic [2:0]          func3_reg;
    logic [31:0]         addr_reg;
    logic [31:0]         wdata_reg;

    logic [31:0]         mem [2**ADDR_W];
    logic [31:0]         ram_rdata_reg;

    logic                rsp_valid_reg;
    logic [31:0]         rsp_rdata_reg;
    logic                rsp_err_reg;

    logic                accept;
    logic                mem_we;
    logic                req_ready_c;
    logic                req_err;
    logic [31:0]         load_data;
    logic [3:0]          wr_be;
    logic [31:0]         wr_data;
    logic [ADDR_W-1:0]   wr_idx;
    logic [ADDR_W-1:0]   rd_idx;

    assign accept = bus.req_valid && req_ready_c;
    assign wr_idx = addr_reg[ADDR_W+1:2];
    assign rd_idx = bus.req_addr[ADDR_W+1:2];

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic: IDLE -> (WAIT) -> RESP -> IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (accept) state_next = (WAIT_CYC > 0) ? S_WAIT : S_RESP;
            S_WAIT: if (wait_cnt_reg == WAIT_LAST) state_next = S_RESP;
            S_RESP: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // FSM outputs: handshake ready, and RAM write strobe during RESP.
    always_comb begin
        req_ready_c = 1'b0;
        mem_we      = 1'b0;
        case (state_reg)
            S_IDLE: req_ready_c = 1'b1;
            S_RESP: mem_we = we_reg && !req_err && !rst;
            default: ;
        endcase
    end

    assign bus.req_ready = req_ready_c;

    // Wait-state counter, running only while in WAIT.
    always_ff @(posedge clk) begin
        if (rst)                    wait_cnt_reg <= 4'd0;
        else if (state_reg == S_WAIT) wait_cnt_reg <= wait_cnt_reg + 4'd1;
        else                        wait_cnt_reg <= 4'd0;
    end

    // Capture the request on the handshake; these fields stay stable until the response.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_reg    <= bus.req_we;
            func3_reg <= bus.req_func3;
            addr_reg  <= bus.req_addr;
            wdata_reg <= bus.req_wdata;
        end
    end

`ifdef DMEM_CYCLE_CNT_EN
    logic [31:0] cyc_cnt_reg;
    logic        is_cnt;

    assign is_cnt = (addr_reg == 32'hFFFF_FF00);

    // Free-running cycle counter, visible through the mapped LW address.
    always_ff @(posedge clk) begin
        if (rst) cyc_cnt_reg <= 32'd0;
        else     cyc_cnt_reg <= cyc_cnt_reg + 32'd1;
    end
`endif

    // Error classification of the latched request.
    always_comb begin
        logic illegal_f3;
        logic misalign;
        logic out_of_range;
        illegal_f3   = (func3_reg == 3'b011) || (func3_reg == 3'b110) ||
                       (func3_reg == 3'b111) || (we_reg && (func3_reg > 3'b010));
        misalign     = ((func3_reg[1:0] == 2'b01) && addr_reg[0]) ||
                       ((func3_reg[1:0] == 2'b10) && (addr_reg[1:0] != 2'b00));
        out_of_range = ((addr_reg >> (ADDR_W + 2)) != 32'd0);
`ifdef DMEM_CYCLE_CNT_EN
        if (is_cnt) req_err = we_reg || (func3_reg != 3'b010);
        else        req_err = illegal_f3 || misalign || out_of_range;
`else
        req_err = illegal_f3 || misalign || out_of_range;
`endif
    end

    // Store lane steering: the byte or halfword is replicated across lanes and
    // gated by per-lane enables.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign wr_data[8*gi +: 8] = (func3_reg[1:0] == 2'b00) ? wdata_reg[7:0] :
                                    (func3_reg[1:0] == 2'b01) ? wdata_reg[8*(gi%2) +: 8] :
                                                                wdata_reg[8*gi +: 8];
        assign wr_be[gi] = (func3_reg[1:0] == 2'b00) ? (addr_reg[1:0] == 2'(gi)) :
                           (func3_reg[1:0] == 2'b01) ? (addr_reg[1] == 1'(gi / 2)) :
                                                       1'b1;
    end

    // RAM: byte-enabled write on the RESP edge; registered read launched at accept.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
        if (accept) ram_rdata_reg <= mem[rd_idx];
    end

    // Lane selection and sign/zero extension of load data.
    always_comb begin
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        lane_b = ram_rdata_reg[{addr_reg[1:0], 3'b000} +: 8];
        lane_h = addr_reg[1] ? ram_rdata_reg[31:16] : ram_rdata_reg[15:0];
        case (func3_reg)
            3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_data = {{16{lane_h[15]}}, lane_h};
            3'b010:  load_data = ram_rdata_reg;
            3'b100:  load_data = {24'd0, lane_b};
            3'b101:  load_data = {16'd0, lane_h};
            default: load_data = 32'd0;
        endcase
`ifdef DMEM_CYCLE_CNT_EN
        if (is_cnt) load_data = cyc_cnt_reg;
`endif
    end

    // Registered response; data and error hold until the next pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= 32'd0;
            rsp_err_reg   <= 1'b0;
        end else begin
            rsp_valid_reg <= (state_reg == S_RESP);
            if (state_reg == S_RESP) begin
                rsp_err_reg   <= req_err;
                rsp_rdata_reg <= (req_err || we_reg) ? 32'd0 : load_data;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_rdata = rsp_rdata_reg;
    assign bus.rsp_err   = rsp_err_reg;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (ADDR_W=8, WAIT_CYC=1).
// Expected responses are queued when a request is driven and popped when rsp_valid pulses.
module tb_data_mem_responder;
    localparam int ADDR_W   = 8;
    localparam int WAIT_CYC = 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        bit          chk;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    data_mem_responder_if bus();

    data_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYC(WAIT_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One handshake plus its response; the expected response goes through the scoreboard queue.
    task automatic xact(input string tag, input bit we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input bit ee, input bit chk,
                        output logic [31:0] got);
        exp_t e;
        int   g;
        int   lat;
        e.rdata = er; e.err = ee; e.chk = chk;
        exp_q.push_back(e);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_func3 = f3;
        bus.req_addr = a; bus.req_wdata = wd;
        g = 0;
        while (!bus.req_ready && g < 50) begin @(negedge clk); g++; end
        check({tag, ":ready"}, 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 0;
        while (!bus.rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        check({tag, ":latency"}, 32'(lat), 32'(WAIT_CYC + 1));
        e = exp_q.pop_front();
        got = bus.rsp_rdata;
        if (e.chk) check({tag, ":rdata"}, bus.rsp_rdata, e.rdata);
        check({tag, ":err"}, 32'(bus.rsp_err), 32'(e.err));
        $display("xact %-10s we=%0d f3=%03b addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
                 tag, we, f3, a, wd, bus.rsp_rdata, bus.rsp_err, lat);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] c1;
        logic [31:0] c2;
        int          pulses;

        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_func3 = 3'b000;
        bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset:ready", 32'(bus.req_ready), 32'd1);
        check("reset:rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset:rdata", bus.rsp_rdata, 32'd0);
        check("reset:err", 32'(bus.rsp_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Word store/load round trip
        xact("sw10", 1, 3'b010, 32'h10, 32'h8000_00F0, 32'h0, 0, 1, got);
        xact("lw10", 0, 3'b010, 32'h10, 32'h0, 32'h8000_00F0, 0, 1, got);

        // Byte stores/loads on lane 3
        xact("sb13a", 1, 3'b000, 32'h13, 32'hFFFF_FF5A, 32'h0, 0, 1, got);
        xact("lb13a", 0, 3'b000, 32'h13, 32'h0, 32'h0000_005A, 0, 1, got);
        xact("sb13b", 1, 3'b000, 32'h13, 32'h0000_00A5, 32'h0, 0, 1, got);
        xact("lb13b", 0, 3'b000, 32'h13, 32'h0, 32'hFFFF_FFA5, 0, 1, got);
        xact("lbu13", 0, 3'b100, 32'h13, 32'h0, 32'h0000_00A5, 0, 1, got);
        xact("lw10b", 0, 3'b010, 32'h10, 32'h0, 32'hA500_00F0, 0, 1, got);

        // Halfword store to upper lanes; lower lanes must survive
        xact("sw20", 1, 3'b010, 32'h20, 32'hCAFE_BEEF, 32'h0, 0, 1, got);
        xact("sh22", 1, 3'b001, 32'h22, 32'h1234_8001, 32'h0, 0, 1, got);
        xact("lh22", 0, 3'b001, 32'h22, 32'h0, 32'hFFFF_8001, 0, 1, got);
        xact("lhu22", 0, 3'b101, 32'h22, 32'h0, 32'h0000_8001, 0, 1, got);
        xact("lw20", 0, 3'b010, 32'h20, 32'h0, 32'h8001_BEEF, 0, 1, got);
        xact("lh20", 0, 3'b001, 32'h20, 32'h0, 32'hFFFF_BEEF, 0, 1, got);
        xact("lbu21", 0, 3'b100, 32'h21, 32'h0, 32'h0000_00BE, 0, 1, got);

        // Range boundaries and error cases
        xact("sw0", 1, 3'b010, 32'h0, 32'h1111_1111, 32'h0, 0, 1, got);
        xact("sw3fc", 1, 3'b010, 32'h3FC, 32'h0BAD_F00D, 32'h0, 0, 1, got);
        xact("lw3fc", 0, 3'b010, 32'h3FC, 32'h0, 32'h0BAD_F00D, 0, 1, got);
        xact("lw11", 0, 3'b010, 32'h11, 32'h0, 32'h0, 1, 1, got);
        xact("lh21", 0, 3'b001, 32'h21, 32'h0, 32'h0, 1, 1, got);
        xact("sw400", 1, 3'b010, 32'h400, 32'hDEAD_BEEF, 32'h0, 1, 1, got);
        xact("sw12", 1, 3'b010, 32'h12, 32'hDEAD_DEAD, 32'h0, 1, 1, got);
        xact("sh11", 1, 3'b001, 32'h11, 32'h0000_7777, 32'h0, 1, 1, got);
        xact("ld_f3_011", 0, 3'b011, 32'h10, 32'h0, 32'h0, 1, 1, got);
        xact("st_f3_100", 1, 3'b100, 32'h10, 32'h0000_0099, 32'h0, 1, 1, got);
        xact("lw0rb", 0, 3'b010, 32'h0, 32'h0, 32'h1111_1111, 0, 1, got);
        xact("lw10rb", 0, 3'b010, 32'h10, 32'h0, 32'hA500_00F0, 0, 1, got);

        // Reset while a store is waiting: aborted, no write, no response
        xact("sw30", 1, 3'b010, 32'h30, 32'h55AA_55AA, 32'h0, 0, 1, got);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_func3 = 3'b010;
        bus.req_addr = 32'h30; bus.req_wdata = 32'h0000_1234;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort:ready", 32'(bus.req_ready), 32'd1);
        pulses = 0;
        repeat (5) begin
            if (bus.rsp_valid) pulses++;
            @(posedge clk); #1;
        end
        check("abort:no_rsp", 32'(pulses), 32'd0);
        $display("xact abort     sw @30 aborted by reset, rsp pulses=%0d", pulses);
        xact("lw30", 0, 3'b010, 32'h30, 32'h0, 32'h55AA_55AA, 0, 1, got);

`ifdef DMEM_CYCLE_CNT_EN
        xact("cnt_lw1", 0, 3'b010, 32'hFFFF_FF00, 32'h0, 32'h0, 0, 0, c1);
        xact("cnt_lw2", 0, 3'b010, 32'hFFFF_FF00, 32'h0, 32'h0, 0, 0, c2);
        check("cnt:delta", c2 - c1, 32'(WAIT_CYC + 2));
        xact("cnt_sw", 1, 3'b010, 32'hFFFF_FF00, 32'h1, 32'h0, 1, 1, got);
        xact("cnt_lh", 0, 3'b001, 32'hFFFF_FF00, 32'h0, 32'h0, 1, 1, got);
`else
        c1 = 32'd0;
        c2 = 32'd0;
        xact("cnt_lw", 0, 3'b010, 32'hFFFF_FF00, 32'h0, 32'h0, 1, 1, got);
`endif

        check("scoreboard:empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
